// File: rtl/and_reduce_seq_pkg.sv
// Shared types and helpers for the sequenced AND reducer: state encoding,
// operand-count limits and a width helper.
package and_reduce_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/and_reduce_seq_if.sv
// Operand-in / result-out handshake bundle for and_reduce_seq.
interface and_reduce_seq_if #(
  parameter int N = 3,
  parameter int W = 1
);
  localparam int SW = and_reduce_seq_pkg::clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_steps;
  logic            out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_steps, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_steps, out_err
  );
endinterface

// File: rtl/and_gate.sv
// Existing 2-input AND cell reused by the fold datapath.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/and_step.sv
// One fold step: a W-wide bank of and_gate cells combining acc with the
// selected operand.
module and_step #(
  parameter int W = 1
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  output logic [W-1:0] next_acc
);
  for (genvar b = 0; b < W; b++) begin : g_bit
    and_gate u_and (
      .a(acc[b]),
      .b(operand[b]),
      .y(next_acc[b])
    );
  end
endmodule

// File: rtl/and_reduce_seq.sv
// Sequenced N-operand AND reducer: folds one operand per cycle through a
// shared and_step bank and cross-checks against a flat reduction.
module and_reduce_seq
  import and_reduce_seq_pkg::*;
#(
  parameter int N          = 3,
  parameter int W          = 1,
  parameter int EARLY_EXIT = 0
) (
  input logic             clk,
  input logic             rst_n,
  and_reduce_seq_if.slave bus
);
  localparam int SW = clog2(N);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("and_reduce_seq: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
  end

  state_t              state;
  logic [N-1:0][W-1:0] ops;
  logic [W-1:0]        acc;
  logic [W-1:0]        next_acc;
  logic [W-1:0]        flat;
  logic [SW-1:0]       idx;
  logic [SW-1:0]       steps;
  logic                done;

  and_step #(.W(W)) u_step (
    .acc     (acc),
    .operand (ops[idx]),
    .next_acc(next_acc)
  );

  // Reference reduction of the captured operands for the self-check flag.
  always_comb begin
    flat = '1;
    for (int i = 0; i < N; i++) flat &= ops[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ops   <= '0;
      acc   <= '0;
      idx   <= '0;
      steps <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          ops   <= bus.in_data;
          acc   <= bus.in_data[W-1:0];
          idx   <= SW'(1);
          steps <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          acc   <= next_acc;
          steps <= steps + SW'(1);
          if (idx == SW'(N-1) || (EARLY_EXIT != 0 && next_acc == '0))
            state <= ST_DONE;
          else
            idx <= idx + SW'(1);
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done          = (state == ST_DONE);
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = done;
  assign bus.out_data  = done ? acc   : '0;
  assign bus.out_steps = done ? steps : '0;
  assign bus.out_err   = done && (acc != flat);
endmodule
